// File: rtl/reg_writeback_arbiter.sv
// Register-file write-back arbiter.
// Two producers (ALU, load unit) compete for the single GPR write port via
// valid/ready handshakes. Ties are broken round-robin. The accepted result
// goes through a one-cycle registered output stage that drives the register
// file, and that same stage feeds the rs1/rs2 forwarding comparators.
module reg_writeback_arbiter #(
   parameter int DATA_WIDTH_POW = 6,
   parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk_in,
   input  logic                      reset,
   // ALU producer
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   // load-unit producer
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]     mem_data,
   // register file write port
   output logic                      regWrite_ctrl,
   output logic [REG_ADDR_WIDTH-1:0] rd_out,
   output logic [DATA_WIDTH-1:0]     writeData_out,
   // decode-side forwarding
   input  logic [REG_ADDR_WIDTH-1:0] rs1_in,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_in,
   output logic                      fwd1_hit,
   output logic                      fwd2_hit,
   output logic [DATA_WIDTH-1:0]     fwd_data
);

   // Round-robin pointer: 1 means the ALU wins the next contended cycle.
   logic                      prio_alu;

   // Handshake and selection for the current cycle (stage p0).
   logic                      alu_xfer;
   logic                      mem_xfer;
   logic                      contend;
   logic                      vld_p0;
   logic [REG_ADDR_WIDTH-1:0] rd_p0;
   logic [DATA_WIDTH-1:0]     data_p0;

   // Registered output stage (stage p1).
   logic                      vld_p1;
   logic [REG_ADDR_WIDTH-1:0] rd_p1;
   logic [DATA_WIDTH-1:0]     data_p1;

   // Readies look only at the competitor's valid, never the source's own,
   // so a producer can sample ready before deciding to raise valid. When
   // both are valid exactly one ready is high, which is what guarantees at
   // most one transfer per cycle.
   assign alu_ready = !reset && (!mem_valid || prio_alu);
   assign mem_ready = !reset && (!alu_valid || !prio_alu);

   assign alu_xfer  = alu_valid && alu_ready;
   assign mem_xfer  = mem_valid && mem_ready;
   assign contend   = alu_valid && mem_valid && !reset;

   // Select the granted producer's result; an x0 destination is accepted
   // but never turns into a register-file write.
   always_comb begin
      vld_p0  = 1'b0;
      rd_p0   = '0;
      data_p0 = '0;
      if (alu_xfer) begin
         vld_p0  = (alu_rd != '0);
         rd_p0   = alu_rd;
         data_p0 = alu_data;
      end else if (mem_xfer) begin
         vld_p0  = (mem_rd != '0);
         rd_p0   = mem_rd;
         data_p0 = mem_data;
      end
   end

   // Round-robin update: only contended grants move the pointer, handing
   // priority to whichever source lost this time.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         prio_alu <= 1'b0;
      end else if (contend) begin
         if (alu_xfer) begin
            prio_alu <= 1'b0;
         end else if (mem_xfer) begin
            prio_alu <= 1'b1;
         end
      end
   end

   // ---- stage boundary p0 -> p1: registered write port ----
   // Write enable pulses for one cycle per non-x0 result; index and data
   // hold their last value otherwise so the port never glitches.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            rd_p1   <= rd_p0;
            data_p1 <= data_p0;
         end
      end
   end

   assign regWrite_ctrl = vld_p1;
   assign rd_out        = rd_p1;
   assign writeData_out = data_p1;

   // Forward the in-flight write. rd_p1 is never x0 while vld_p1 is set,
   // so x0 reads cannot pick up a bypass.
   assign fwd1_hit = vld_p1 && (rd_p1 == rs1_in);
   assign fwd2_hit = vld_p1 && (rd_p1 == rs2_in);
   assign fwd_data = data_p1;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed testbench for reg_writeback_arbiter. Stimulus pushes the expected
// register-file writes into a queue; a monitor pops and compares on every
// cycle the DUT asserts regWrite_ctrl.
module tb_reg_writeback_arbiter;

   localparam int DW = 64;
   localparam int AW = 5;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          alu_valid, alu_ready;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          mem_valid, mem_ready;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          regWrite_ctrl;
   logic [AW-1:0] rd_out;
   logic [DW-1:0] writeData_out;
   logic [AW-1:0] rs1_in, rs2_in;
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd_data;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wr_t;

   wr_t sb[$];
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b0;

   reg_writeback_arbiter #(.DATA_WIDTH_POW(6), .REG_ADDR_WIDTH(AW)) dut (
      .clk_in(clk_in), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .regWrite_ctrl(regWrite_ctrl), .rd_out(rd_out), .writeData_out(writeData_out),
      .rs1_in(rs1_in), .rs2_in(rs2_in),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      wr_t w;
      w.rd   = rd;
      w.data = data;
      sb.push_back(w);
   endtask

   // Monitor: every register-file write must match the oldest expectation.
   always @(negedge clk_in) begin
      if (mon_en && regWrite_ctrl !== 1'b0) begin
         wr_t w;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: write rd=%0d data=0x%0h with nothing expected at %0t",
                     rd_out, writeData_out, $time);
         end else begin
            w = sb.pop_front();
            chk("sb_rd", {{(DW-AW){1'b0}}, rd_out}, {{(DW-AW){1'b0}}, w.rd});
            chk("sb_data", writeData_out, w.data);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      rs1_in = '0; rs2_in = '0;

      // 1: reset held two cycles, readies low throughout
      step();
      @(negedge clk_in);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      step();
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk_in);
      chk("rst_regwrite", regWrite_ctrl, 0);
      chk("rst_rd_out", rd_out, 0);
      chk("rst_wdata", writeData_out, 0);
      chk("idle_alu_ready", alu_ready, 1);
      chk("idle_mem_ready", mem_ready, 1);

      // 2: lone ALU result, one-cycle latency, single-cycle pulse
      step();
      alu_valid = 1'b1; alu_rd = 5; alu_data = 64'hDEAD_BEEF;
      push(5, 64'hDEAD_BEEF);
      @(negedge clk_in);
      chk("alu_only_ready", alu_ready, 1);
      step();
      alu_valid = 1'b0;
      @(negedge clk_in);
      chk("alu_only_we", regWrite_ctrl, 1);
      step();
      @(negedge clk_in);
      chk("alu_only_we_drop", regWrite_ctrl, 0);

      // 3: continuous contention after reset: mem, alu, mem, alu
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      alu_valid = 1'b1; alu_rd = 3; alu_data = 64'hA3;
      mem_valid = 1'b1; mem_rd = 4; mem_data = 64'hB4;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push(4, 64'hB4);
         else            push(3, 64'hA3);
         @(negedge clk_in);
         chk("rr_alu_ready", alu_ready, (i % 2 == 1) ? 1 : 0);
         chk("rr_mem_ready", mem_ready, (i % 2 == 0) ? 1 : 0);
         step();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;

      // 4: load to x0 is accepted and discarded
      step();
      mem_valid = 1'b1; mem_rd = 0; mem_data = 64'h1234;
      @(negedge clk_in);
      chk("x0_mem_ready", mem_ready, 1);
      step();
      mem_valid = 1'b0;
      @(negedge clk_in);
      chk("x0_we", regWrite_ctrl, 0);
      chk("x0_rd_hold", rd_out, 3);
      chk("x0_data_hold", writeData_out, 64'hA3);

      // 5: forwarding of the in-flight write
      step();
      alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h55;
      push(7, 64'h55);
      step();
      alu_valid = 1'b0;
      rs1_in = 7; rs2_in = 8;
      @(negedge clk_in);
      chk("fwd1_hit", fwd1_hit, 1);
      chk("fwd2_miss", fwd2_hit, 0);
      chk("fwd_data", fwd_data, 64'h55);
      step();
      @(negedge clk_in);
      chk("fwd1_expired", fwd1_hit, 0);
      rs1_in = 0; rs2_in = 0;

      // 6: reset after an accepted write restores load-first priority
      step();
      alu_valid = 1'b1; alu_rd = 9;  alu_data = 64'h99;
      mem_valid = 1'b1; mem_rd = 10; mem_data = 64'hAA;
      push(10, 64'hAA);
      @(negedge clk_in);
      chk("r6_mem_first", mem_ready, 1);
      step();
      mem_valid = 1'b0;
      push(9, 64'h99);
      @(negedge clk_in);
      chk("r6_alu_ready", alu_ready, 1);
      step();
      reset = 1'b1;
      alu_valid = 1'b1; alu_rd = 12; alu_data = 64'hCC;
      mem_valid = 1'b1; mem_rd = 11; mem_data = 64'hBB;
      @(negedge clk_in);
      chk("r6_rst_alu_ready", alu_ready, 0);
      chk("r6_rst_mem_ready", mem_ready, 0);
      step();
      reset = 1'b0;
      push(11, 64'hBB);
      @(negedge clk_in);
      chk("r6_we_cleared", regWrite_ctrl, 0);
      chk("r6_rd_cleared", rd_out, 0);
      chk("r6_data_cleared", writeData_out, 0);
      chk("r6_post_mem_ready", mem_ready, 1);
      chk("r6_post_alu_ready", alu_ready, 0);
      step();
      mem_valid = 1'b0;
      push(12, 64'hCC);
      step();
      alu_valid = 1'b0;
      step();
      step();
      @(negedge clk_in);
      chk("sb_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
